// File: rtl/set_assoc_cache_pkg.sv
// Shared definitions for the 2-way read-only cache: FSM encoding, default
// geometry and helpers that derive the tag/index/offset field widths.
package set_assoc_cache_pkg;

  localparam int ADDRESSL_DEF   = 15;
  localparam int WORD_DEF       = 32;
  localparam int BLOCKWORDS_DEF = 4;
  localparam int SETS_DEF       = 256;
  localparam int CNTW_DEF       = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    REFILL  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  function automatic int offset_width(input int blockwords);
    return $clog2(blockwords);
  endfunction

  function automatic int index_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int addressl, input int sets, input int blockwords);
    return addressl - $clog2(sets) - $clog2(blockwords);
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Request/response and backing-RAM bundle; slave is the cache side.
interface set_assoc_cache_if
  import set_assoc_cache_pkg::*;
#(
  parameter int ADDRESSL = ADDRESSL_DEF,
  parameter int WORD     = WORD_DEF,
  parameter int CNTW     = CNTW_DEF
);
  logic                req_valid;
  logic                req_ready;
  logic [ADDRESSL-1:0] address;
  logic [WORD-1:0]     data_out;
  logic                data_valid;
  logic                mem_rd;
  logic [ADDRESSL-1:0] mem_adr;
  logic                mem_valid;
  logic [WORD-1:0]     mem_data;
  logic [CNTW-1:0]     hit_count;
  logic [CNTW-1:0]     miss_count;
  logic                flush;

  modport slave (
    input  req_valid, address, mem_valid, mem_data, flush,
    output req_ready, data_out, data_valid, mem_rd, mem_adr, hit_count, miss_count
  );

  modport master (
    output req_valid, address, mem_valid, mem_data, flush,
    input  req_ready, data_out, data_valid, mem_rd, mem_adr, hit_count, miss_count
  );
endinterface

// File: rtl/cache_way.sv
// One cache way: tag and data arrays with a synchronous write port and an
// asynchronous read port sharing the set index.
module cache_way #(
  parameter int WORD       = 32,
  parameter int TAG_W      = 5,
  parameter int IDX_W      = 8,
  parameter int OFF_W      = 2,
  parameter int SETS       = 256,
  parameter int BLOCKWORDS = 4
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] index,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             data_we,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [WORD-1:0]  wr_data,
  input  logic [OFF_W-1:0] rd_offset,
  output logic [TAG_W-1:0] rd_tag,
  output logic [WORD-1:0]  rd_data
);
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [WORD-1:0]  data_mem [SETS*BLOCKWORDS];

  always_ff @(posedge clk) begin
    if (tag_we)
      tag_mem[index] <= wr_tag;
    if (data_we)
      data_mem[{index, wr_offset}] <= wr_data;
  end

  assign rd_tag  = tag_mem[index];
  assign rd_data = data_mem[{index, rd_offset}];
endmodule

// File: rtl/set_assoc_cache.sv
// 2-way set-associative read-only cache with per-set LRU, line refill from a
// word-wide backing RAM, flush, and saturating hit/miss counters.
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int ADDRESSL   = ADDRESSL_DEF,
  parameter int WORD       = WORD_DEF,
  parameter int BLOCKWORDS = BLOCKWORDS_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int CNTW       = CNTW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  set_assoc_cache_if.slave   bus
);
  localparam int OFF_W = offset_width(BLOCKWORDS);
  localparam int IDX_W = index_width(SETS);
  localparam int TAG_W = tag_width(ADDRESSL, SETS, BLOCKWORDS);

  state_t              state;
  logic [ADDRESSL-1:0] addr_reg;
  logic [OFF_W-1:0]    beat;
  logic                victim;
  logic [WORD-1:0]     fill_word;
  logic [SETS-1:0]     valid [2];
  logic [SETS-1:0]     lru;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  assign tag = addr_reg[ADDRESSL-1 -: TAG_W];
  assign idx = addr_reg[OFF_W +: IDX_W];
  assign off = addr_reg[OFF_W-1:0];

  logic [TAG_W-1:0] way_tag  [2];
  logic [WORD-1:0]  way_data [2];
  logic [1:0]       way_hit;
  logic             fill_we;
  logic             last_beat;
  logic             pick;

  assign fill_we   = (state == REFILL) && bus.mem_valid;
  assign last_beat = (beat == OFF_W'(BLOCKWORDS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      cache_way #(
        .WORD(WORD), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W),
        .SETS(SETS), .BLOCKWORDS(BLOCKWORDS)
      ) u_way (
        .clk       (clk),
        .index     (idx),
        .tag_we    (fill_we && last_beat && (victim == 1'(gi))),
        .wr_tag    (tag),
        .data_we   (fill_we && (victim == 1'(gi))),
        .wr_offset (beat),
        .wr_data   (bus.mem_data),
        .rd_offset (off),
        .rd_tag    (way_tag[gi]),
        .rd_data   (way_data[gi])
      );
      assign way_hit[gi] = valid[gi][idx] && (way_tag[gi] == tag);
    end
  endgenerate

  // Fill an empty way first; only consult LRU when both ways are occupied.
  always_comb begin
    pick = lru[idx];
    if (!valid[0][idx])
      pick = 1'b0;
    else if (!valid[1][idx])
      pick = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      addr_reg       <= '0;
      beat           <= '0;
      victim         <= 1'b0;
      fill_word      <= '0;
      valid[0]       <= '0;
      valid[1]       <= '0;
      lru            <= '0;
      bus.req_ready  <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.data_out   <= '0;
      bus.mem_rd     <= 1'b0;
      bus.mem_adr    <= '0;
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            valid[0]      <= '0;
            valid[1]      <= '0;
            lru           <= '0;
            bus.req_ready <= 1'b1;
          end else if (bus.req_valid && bus.req_ready) begin
            addr_reg      <= bus.address;
            bus.req_ready <= 1'b0;
            state         <= LOOKUP;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        LOOKUP: begin
          if (|way_hit) begin
            bus.data_out   <= way_hit[1] ? way_data[1] : way_data[0];
            bus.data_valid <= 1'b1;
            lru[idx]       <= ~way_hit[1];
            bus.hit_count  <= (&bus.hit_count) ? bus.hit_count : bus.hit_count + CNTW'(1);
            state          <= RESPOND;
          end else begin
            victim         <= pick;
            beat           <= '0;
            bus.mem_rd     <= 1'b1;
            bus.mem_adr    <= {tag, idx, {OFF_W{1'b0}}};
            bus.miss_count <= (&bus.miss_count) ? bus.miss_count : bus.miss_count + CNTW'(1);
            state          <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_valid) begin
            if (beat == off)
              fill_word <= bus.mem_data;
            // The line only becomes valid once its final beat lands.
            if (last_beat) begin
              valid[victim][idx] <= 1'b1;
              lru[idx]           <= ~victim;
              bus.mem_rd         <= 1'b0;
              bus.data_valid     <= 1'b1;
              bus.data_out       <= (beat == off) ? bus.mem_data : fill_word;
              state              <= RESPOND;
            end else begin
              beat        <= beat + OFF_W'(1);
              bus.mem_adr <= bus.mem_adr + ADDRESSL'(1);
            end
          end
        end
        RESPOND: begin
          bus.data_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter ADDRESSL, 15, word address width.
REQ-002 Parameter WORD, 32, data word width.
REQ-003 Parameter BLOCKWORDS, 4, words per line; power of two, at least 2.
REQ-004 Parameter SETS, 256, number of sets; power of two.
REQ-005 Parameter CNTW, 15, width of the hit and miss counters.
REQ-006 The block SHALL have one clock, clk; reset is asynchronous and active-low, port rst.
REQ-007 The ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-low reset
- req_valid  in  1  read request
- req_ready  out  1  block can accept a request
- address  in  ADDRESSL  word address
- data_out  out  WORD  read data
- data_valid  out  1  data_out valid, single-cycle pulse
- mem_rd  out  1  backing-RAM beat request
- mem_adr  out  ADDRESSL  backing-RAM word address
- mem_valid  in  1  mem_data valid for the current beat
- mem_data  in  WORD  backing-RAM data
- hit_count  out  CNTW  saturating hit counter
- miss_count  out  CNTW  saturating miss counter
- flush  in  1  invalidate all lines

Function
REQ-008 The cache SHALL be 2-way set-associative and read-only, with address split into tag | index (log2 SETS) | offset (log2 BLOCKWORDS).
REQ-009 The FSM SHALL have the states IDLE, LOOKUP, REFILL, RESPOND, and req_ready SHALL be 1 only in IDLE.
REQ-010 A request SHALL be accepted when req_valid and req_ready are both 1 at a clk edge, and the address SHALL be registered; the FSM then goes IDLE->LOOKUP.
REQ-011 In LOOKUP the block SHALL compare the tag against both ways of the set; a match in a valid way is a hit and the FSM goes LOOKUP->RESPOND.
REQ-012 For a hit, data_valid SHALL go high exactly 2 cycles after acceptance, with data_out set to the addressed word.
REQ-013 On a miss the FSM SHALL go LOOKUP->REFILL.
REQ-014 In REFILL, mem_rd SHALL stay high and mem_adr SHALL equal line base + beat (beat = 0 to BLOCKWORDS-1); the beat advances on each mem_valid.
REQ-015 After beat BLOCKWORDS-1, the line SHALL be written, the tag and valid bit set, and the FSM SHALL go to RESPOND, returning the requested word.
REQ-016 In RESPOND, data_valid SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-017 The victim SHALL be the first invalid way (way0 before way1); if both are valid, the way indicated by the per-set LRU bit.
REQ-018 The LRU bit SHALL be updated to point at the other way on every hit and every fill.
REQ-019 hit_count SHALL increment on each LOOKUP hit and miss_count on each LOOKUP miss; each SHALL saturate at all-ones.
REQ-020 flush SHALL clear all valid bits and LRU bits in 1 cycle, and SHALL be honoured only in IDLE.
REQ-021 flush in IDLE SHALL block acceptance in that cycle; flush in any other state SHALL be ignored.
REQ-022 mem_rd SHALL be 0 in every state except REFILL.
REQ-023 data_out SHALL hold its last value when data_valid is 0.

Reset
REQ-024 rst low SHALL asynchronously force: state IDLE, all valid and LRU bits 0, counters 0, data_valid 0, mem_rd 0, mem_adr 0, data_out 0, beat 0.
REQ-025 Reset during REFILL SHALL abandon the refill with no partial line marked valid.
REQ-026 req_ready SHALL be 1 from the first edge after reset release.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the derived widths (tag, index, offset).
REQ-028 Data and tag storage SHALL be one sub-module, cache_way, instantiated twice, each with a synchronous write port and an asynchronous read port.

Verification
REQ-029 Scenario 1: after reset, read 0x0010 -> miss; mem_adr 0x0010 to 0x0013; data_valid with the RAM word; miss_count=1.
REQ-030 Scenario 2: read 0x0011 again -> data_valid 2 cycles after acceptance, mem_rd never high, hit_count=1.
REQ-031 Scenario 3: read 0x0010, 0x0410, 0x0810 (same set) -> the third read evicts the 0x0010 line; rereading 0x0410 hits and rereading 0x0010 misses.
REQ-032 Scenario 4: flush in IDLE, then read 0x0011 -> miss; hit_count unchanged.
REQ-033 Scenario 5: rst low during REFILL beat 2 -> all outputs reset; a later read of the same address misses.
REQ-034 Scenario 6: preload hit_count to all-ones (CNTW=4 build), then one more hit -> hit_count stays 0xF.
